// File: rtl/board_ram_arbiter.sv
// Game board storage: a dedicated 1-cycle display read port plus one shared logic port
// arbitrated between move writes, win-check reads and a clear sequencer. Define BOARD_ARB_RR_EN for round-robin write/read arbitration.
module board_ram_arbiter #(
  parameter int CELLS = 100,
  parameter int AW    = 7,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          clr_start,
  output logic          busy,
  output logic          clr_done,
  output logic          err
);

  typedef enum logic [0:0] {CLEAR = 1'b0, SERVE = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW:0]   CELLS_W   = (AW + 1)'(CELLS);

  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < CELLS_W);
  endfunction

  state_t        state_r, state_nxt_s;
  logic [AW-1:0] clr_ptr_r, clr_ptr_nxt_s;
  logic          wr_gnt_s, rd_gnt_s, clr_fin_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_waddr_s;
  logic [DW-1:0] mem_wdata_s;
  logic [DW-1:0] mem_r [2**AW];
  logic [DW-1:0] disp_data_r, rd_data_r;
  logic          rd_valid_r, clr_done_r, err_r;

`ifdef BOARD_ARB_RR_EN
  // 1 = write was granted most recently, 0 = read (reset value)
  logic last_grant_r;
`endif

  // Next-state, grant and memory-write-port selection
  always_comb begin
    state_nxt_s   = state_r;
    clr_ptr_nxt_s = clr_ptr_r;
    wr_gnt_s      = 1'b0;
    rd_gnt_s      = 1'b0;
    clr_fin_s     = 1'b0;
    mem_we_s      = 1'b0;
    mem_waddr_s   = {AW{1'b0}};
    mem_wdata_s   = {DW{1'b0}};
    if (rst) begin
      // grants are withheld so a reset cycle never commits an access
      state_nxt_s = CLEAR;
    end else begin
      case (state_r)
        CLEAR: begin
          mem_we_s    = 1'b1;
          mem_waddr_s = clr_ptr_r;
          if (clr_ptr_r == LAST_CELL) begin
            state_nxt_s   = SERVE;
            clr_ptr_nxt_s = {AW{1'b0}};
            clr_fin_s     = 1'b1;
          end else begin
            clr_ptr_nxt_s = clr_ptr_r + AW'(1);
          end
        end
        SERVE: begin
          if (clr_start) begin
            state_nxt_s   = CLEAR;
            clr_ptr_nxt_s = {AW{1'b0}};
          end else begin
`ifdef BOARD_ARB_RR_EN
            if (wr_req && (!rd_req || !last_grant_r)) begin
              wr_gnt_s = 1'b1;
            end else if (rd_req) begin
              rd_gnt_s = 1'b1;
            end else begin
              wr_gnt_s = 1'b0;
            end
`else
            if (wr_req) begin
              wr_gnt_s = 1'b1;
            end else if (rd_req) begin
              rd_gnt_s = 1'b1;
            end else begin
              wr_gnt_s = 1'b0;
            end
`endif
            // out-of-range writes are granted but dropped
            if (wr_gnt_s && in_range(wr_addr)) begin
              mem_we_s    = 1'b1;
              mem_waddr_s = wr_addr;
              mem_wdata_s = wr_data;
            end else begin
              mem_we_s = 1'b0;
            end
          end
        end
        default: begin
          state_nxt_s   = CLEAR;
          clr_ptr_nxt_s = {AW{1'b0}};
        end
      endcase
    end
  end

  // FSM state and clear pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_ptr_r <= {AW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      clr_ptr_r <= clr_ptr_nxt_s;
    end
  end

`ifdef BOARD_ARB_RR_EN
  // Round-robin history of the last granted requester
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b0;
    end else if (wr_gnt_s) begin
      last_grant_r <= 1'b1;
    end else if (rd_gnt_s) begin
      last_grant_r <= 1'b0;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Board storage write port (no reset; every reset runs a full clear)
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Display read port: old data on a same-address write
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_data_r <= {DW{1'b0}};
    end else begin
      disp_data_r <= mem_r[disp_addr];
    end
  end

  // Logic-port read data, error and clear-done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DW{1'b0}};
      clr_done_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      rd_valid_r <= rd_gnt_s;
      clr_done_r <= clr_fin_s;
      err_r      <= (wr_gnt_s && !in_range(wr_addr)) || (rd_gnt_s && !in_range(rd_addr));
      if (rd_gnt_s) begin
        rd_data_r <= in_range(rd_addr) ? mem_r[rd_addr] : {DW{1'b0}};
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign wr_gnt    = wr_gnt_s;
  assign rd_gnt    = rd_gnt_s;
  assign busy      = (state_r == CLEAR);
  assign disp_data = disp_data_r;
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_data_r;
  assign clr_done  = clr_done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Self-checking bench for board_ram_arbiter: cycle-level reference model of the board,
// a vector table for the write/read/priority corners, and hand-written clear/reset sequences.
module tb_board_ram_arbiter;

  localparam int        CELLS = 100;
  localparam logic [6:0] NCELL = 7'd100;

  logic       clk, rst;
  logic [6:0] disp_addr, wr_addr, rd_addr;
  logic [1:0] disp_data, wr_data, rd_data;
  logic       wr_req, wr_gnt, rd_req, rd_gnt, rd_valid, clr_start, busy, clr_done, err;

  board_ram_arbiter #(.CELLS(100), .AW(7), .DW(2)) dut (
    .clk(clk), .rst(rst), .disp_addr(disp_addr), .disp_data(disp_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .clr_start(clr_start), .busy(busy), .clr_done(clr_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: board contents and the outputs expected for the current cycle
  logic [1:0] m_mem [128];
  bit         m_known [128];
  int         m_clear_left;
  bit         m_last_wr;
  logic       e_rd_valid, e_err, e_clr_done;
  logic [1:0] e_rd_data, e_disp;
  bit         e_disp_ok;
  bit         chk_en;
  bit         g_wr, g_rd;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // at the negedge: predict grants and compare every output
  task automatic sample();
    @(negedge clk);
    g_wr = 1'b0;
    g_rd = 1'b0;
    if (!rst && m_clear_left == 0 && !clr_start) begin
      if (wr_req && rd_req) begin
`ifdef BOARD_ARB_RR_EN
        if (m_last_wr) g_rd = 1'b1;
        else g_wr = 1'b1;
`else
        g_wr = 1'b1;
`endif
      end else begin
        g_wr = wr_req;
        g_rd = rd_req;
      end
    end
    if (chk_en) begin
      chk("wr_gnt", int'(wr_gnt), int'(g_wr));
      chk("rd_gnt", int'(rd_gnt), int'(g_rd));
      chk("busy", int'(busy), int'(m_clear_left > 0));
      chk("rd_valid", int'(rd_valid), int'(e_rd_valid));
      chk("rd_data", int'(rd_data), int'(e_rd_data));
      chk("err", int'(err), int'(e_err));
      chk("clr_done", int'(clr_done), int'(e_clr_done));
      if (e_disp_ok) chk("disp_data", int'(disp_data), int'(e_disp));
    end
  endtask

  // apply this cycle's effects to the model, then move past the rising edge
  task automatic advance();
    logic [1:0] nd;
    bit         nd_ok;
    nd    = m_mem[disp_addr];
    nd_ok = (disp_addr < NCELL) && m_known[disp_addr];
    if (rst) begin
      m_clear_left = CELLS;
      m_last_wr    = 1'b0;
      e_rd_valid   = 1'b0;
      e_rd_data    = 2'b00;
      e_err        = 1'b0;
      e_clr_done   = 1'b0;
      e_disp       = 2'b00;
      e_disp_ok    = 1'b1;
    end else begin
      e_disp     = nd;
      e_disp_ok  = nd_ok;
      e_clr_done = 1'b0;
      e_err      = 1'b0;
      e_rd_valid = 1'b0;
      if (m_clear_left > 0) begin
        m_mem[CELLS - m_clear_left]   = 2'b00;
        m_known[CELLS - m_clear_left] = 1'b1;
        m_clear_left--;
        if (m_clear_left == 0) e_clr_done = 1'b1;
      end else if (clr_start) begin
        m_clear_left = CELLS;
      end else if (g_wr) begin
        m_last_wr = 1'b1;
        if (wr_addr < NCELL) begin
          m_mem[wr_addr]   = wr_data;
          m_known[wr_addr] = 1'b1;
        end else begin
          e_err = 1'b1;
        end
      end else if (g_rd) begin
        m_last_wr  = 1'b0;
        e_rd_valid = 1'b1;
        e_rd_data  = (rd_addr < NCELL) ? m_mem[rd_addr] : 2'b00;
        e_err      = (rd_addr >= NCELL);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  typedef struct {
    logic       wr_req;
    logic [6:0] wr_addr;
    logic [1:0] wr_data;
    logic       rd_req;
    logic [6:0] rd_addr;
    logic       e_wg, e_rg, e_rv;
    logic [1:0] e_rd;
    logic       e_err;
    logic [1:0] e_disp;
  } vec_t;

  vec_t tbl [13];
  int   busy_cnt, done_cnt, done_at, first_idle, rv_busy;

  initial begin
    // write 45 then read it, out-of-range write/read of 100, then 4 cycles of contention
    tbl[0]  = '{1'b1, 7'd45,  2'b01, 1'b0, 7'd0,   1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[1]  = '{1'b0, 7'd0,   2'b00, 1'b1, 7'd45,  1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[2]  = '{1'b0, 7'd0,   2'b00, 1'b0, 7'd0,   1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01};
    tbl[3]  = '{1'b1, 7'd100, 2'b10, 1'b0, 7'd0,   1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 2'b01};
    tbl[4]  = '{1'b0, 7'd0,   2'b00, 1'b1, 7'd100, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 2'b01};
    tbl[5]  = '{1'b0, 7'd0,   2'b00, 1'b0, 7'd0,   1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b01};
    tbl[6]  = '{1'b0, 7'd0,   2'b00, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
`ifdef BOARD_ARB_RR_EN
    tbl[7]  = '{1'b1, 7'd3,   2'b11, 1'b1, 7'd45,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
    tbl[8]  = '{1'b1, 7'd3,   2'b11, 1'b1, 7'd45,  1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01};
    tbl[9]  = '{1'b1, 7'd3,   2'b11, 1'b1, 7'd45,  1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01};
    tbl[10] = '{1'b1, 7'd3,   2'b11, 1'b1, 7'd45,  1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01};
    tbl[11] = '{1'b0, 7'd0,   2'b00, 1'b0, 7'd0,   1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b01};
    tbl[12] = '{1'b0, 7'd0,   2'b00, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b01};
`else
    for (int r = 7; r <= 10; r++)
      tbl[r] = '{1'b1, 7'd3,  2'b11, 1'b1, 7'd45,  1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
    tbl[11] = '{1'b0, 7'd0,   2'b00, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
    tbl[12] = '{1'b0, 7'd0,   2'b00, 1'b0, 7'd0,   1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01};
`endif

    for (int a = 0; a < 128; a++) begin
      m_mem[a]   = 2'b00;
      m_known[a] = 1'b0;
    end
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; clr_start = 1'b0;
    wr_addr = 7'd0; wr_data = 2'b00; rd_addr = 7'd0; disp_addr = 7'd0;
    chk_en = 1'b0;
    cycle();
    chk_en = 1'b1;
    cycle();
    rst = 1'b0;

    // clear after reset release
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      if (busy) busy_cnt++;
      if (clr_done) done_cnt++;
      cycle();
    end
    chk("busy_cycles_after_reset", busy_cnt, 100);
    chk("clr_done_pulses_after_reset", done_cnt, 1);

    // read sweep of the whole board
    for (int a = 0; a < CELLS; a++) begin
      rd_req = 1'b1; rd_addr = 7'(a); disp_addr = 7'(a);
      cycle();
    end
    rd_req = 1'b0; disp_addr = 7'd45;
    cycle();
    cycle();

    // vector table
    for (int r = 0; r < 13; r++) begin
      wr_req = tbl[r].wr_req; wr_addr = tbl[r].wr_addr; wr_data = tbl[r].wr_data;
      rd_req = tbl[r].rd_req; rd_addr = tbl[r].rd_addr;
      sample();
      chk($sformatf("tbl%0d_wr_gnt", r), int'(wr_gnt), int'(tbl[r].e_wg));
      chk($sformatf("tbl%0d_rd_gnt", r), int'(rd_gnt), int'(tbl[r].e_rg));
      chk($sformatf("tbl%0d_rd_valid", r), int'(rd_valid), int'(tbl[r].e_rv));
      chk($sformatf("tbl%0d_rd_data", r), int'(rd_data), int'(tbl[r].e_rd));
      chk($sformatf("tbl%0d_err", r), int'(err), int'(tbl[r].e_err));
      chk($sformatf("tbl%0d_disp", r), int'(disp_data), int'(tbl[r].e_disp));
      advance();
    end

    // fill the board, then clear with a second clr_start and a write held through the clear
    for (int a = 0; a < CELLS; a++) begin
      wr_req = 1'b1; wr_addr = 7'(a); wr_data = 2'($urandom_range(1, 3));
      cycle();
    end
    wr_req = 1'b0;
    cycle();
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    done_cnt = 0; done_at = -1; first_idle = -1;
    for (int i = 0; i < 130; i++) begin
      if (clr_done) begin done_cnt++; done_at = i; end
      if (!busy && first_idle < 0) begin
        first_idle = i;
        chk("wr_gnt_when_busy_falls", int'(wr_gnt), 1);
      end
      clr_start = (i == 20);
      if (i == 30) begin wr_req = 1'b1; wr_addr = 7'd5; wr_data = 2'b10; end
      cycle();
      if (g_wr) wr_req = 1'b0;
    end
    chk("clr_done_count", done_cnt, 1);
    chk("clr_done_latency", done_at, 100);
    chk("first_idle_cycle", first_idle, 100);

    // reset in the middle of a clear with a read pending
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    repeat (50) cycle();
    rd_req = 1'b1; rd_addr = 7'd7; rst = 1'b1;
    cycle();
    rst = 1'b0;
    busy_cnt = 0; rv_busy = 0;
    for (int i = 0; i < 150; i++) begin
      if (busy) busy_cnt++;
      if (busy && rd_valid) rv_busy++;
      cycle();
      if (g_rd) rd_req = 1'b0;
    end
    chk("busy_after_midclear_reset", busy_cnt, 100);
    chk("rd_valid_during_clear", rv_busy, 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (!wr_req) begin
        wr_req  = ($urandom_range(0, 2) == 0);
        wr_addr = 7'($urandom_range(0, 127));
        wr_data = 2'($urandom_range(0, 3));
      end
      if (!rd_req) begin
        rd_req  = ($urandom_range(0, 1) == 0);
        rd_addr = 7'($urandom_range(0, 127));
      end
      clr_start = ($urandom_range(0, 149) == 0);
      disp_addr = 7'($urandom_range(0, 127));
      cycle();
      if (g_wr) wr_req = 1'b0;
      if (g_rd) rd_req = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0; clr_start = 1'b0;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/board_ram_arbiter.md
# board_ram_arbiter

Owns the game board storage: CELLS cells of DW bits, each 00 empty, 01 triangle, 10 circle, 11 expired. It gives the display path a dedicated, fixed-latency read port. A single shared logic port is arbitrated between three users: a move-write requester, a win-check read requester, and an internal clear sequencer. It sits between the game controller FSM, the win checker and the VGA renderer, and replaces ad-hoc board array access and loop-based clearing with a sequenced, one-access-per-cycle resource.

## Interface
- CELLS, 100, number of valid cells (10x10 board, index = row*10 + col)
- AW, 7, address width; storage depth is 2^AW
- DW, 2, cell width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- disp_addr  in  AW  display read address, sampled every cycle
- disp_data  out  DW  display read data, registered
- wr_req  in  1  move write request; hold until wr_gnt
- wr_addr  in  AW  write address; stable while wr_req
- wr_data  in  DW  write data; stable while wr_req
- wr_gnt  out  1  combinational; write commits on this edge
- rd_req  in  1  win-check read request; hold until rd_gnt
- rd_addr  in  AW  read address; stable while rd_req
- rd_gnt  out  1  combinational read accept
- rd_valid  out  1  registered; one cycle after rd_gnt
- rd_data  out  DW  valid while rd_valid
- clr_start  in  1  single-cycle pulse that starts a board clear
- busy  out  1  clear sequencer active
- clr_done  out  1  one-cycle pulse after the last clear write
- err  out  1  one-cycle pulse; the granted access had address >= CELLS

## Operation
- FSM has two states, CLEAR and SERVE. rst forces CLEAR with clr_ptr=0, so every reset clears the board.
- CLEAR state:
  - Each cycle writes 0 to cell clr_ptr, then clr_ptr increments.
  - Cells CELLS..2^AW-1 are never touched.
  - The edge that writes cell CELLS-1 moves the FSM to SERVE, drops busy and pulses clr_done.
  - wr_gnt and rd_gnt stay 0 throughout.
- SERVE state:
  - clr_start moves the FSM to CLEAR with clr_ptr=0. No grant is issued in that cycle.
  - Otherwise wr_req is granted over rd_req (fixed priority; see Configuration).
  - At most one grant per cycle.
- clr_start while busy is ignored; the clear in progress is neither restarted nor extended.
- Out-of-range addresses (>= CELLS):
  - The access is still granted.
  - A write is dropped and a read returns 0.
  - err pulses on the cycle after the grant, aligned with rd_valid for reads.
- Display port:
  - disp_data <= mem[disp_addr] every cycle, independent of FSM state.
  - On a same-cycle write to the same address, disp_data returns the old value (read-before-write).
- A requester that keeps req high after its gnt cycle is presenting a new request.

## Timing
- Reset values: disp_data=0, wr_gnt=0, rd_gnt=0, rd_valid=0, rd_data=0, busy=1, clr_done=0, err=0, state=CLEAR, clr_ptr=0.
- Clear after reset:
  - Cell 0 is written on the first edge with rst=0.
  - Cell CELLS-1 is written on edge CELLS.
  - busy=0 and clr_done=1 during the following cycle, so clear latency is CELLS cycles.
- clr_start sampled on edge N: cell 0 is written on edge N+1, and clr_done is high for one cycle after edge N+CELLS.
- Write: wr_gnt is high in the cycle wr_req is selected. mem is updated on that edge, and a read granted in the next cycle sees the new value.
- Read: rd_gnt in cycle T gives rd_valid=1 with rd_data in cycle T+1. rd_valid is 0 otherwise, and rd_data holds its last value.
- Display latency is 1 cycle at all times, including during CLEAR.
- rst asserted mid-clear or mid-access: any pending grant is lost and rd_valid is forced to 0. Requesters re-issue after busy falls.

## Configuration
- BOARD_ARB_RR_EN defined:
  - Write and read requests in SERVE are arbitrated round-robin.
  - A 1-bit last_grant register (reset = read) makes the requester not granted most recently win a simultaneous request.
  - A lone request is granted immediately.
- BOARD_ARB_RR_EN undefined: fixed priority, write over read. last_grant is not implemented.

## Test plan
- Reset release, all requests low:
  - busy=1 for exactly 100 cycles, then clr_done pulses once.
  - Reads of 0..99 all return 00 with rd_valid exactly one cycle after each rd_gnt.
- Write 2'b01 to 45, then read 45 on the next cycle: wr_gnt 1 cycle, rd_gnt next cycle, rd_data=01 one cycle later. disp_addr=45 shows 01 one cycle after the write edge.
- wr_req and rd_req held together for 4 cycles:
  - Without the macro: wr, wr, wr, wr (with wr_req re-presented each cycle); rd is starved until wr_req drops.
  - With BOARD_ARB_RR_EN: grants alternate wr, rd, wr, rd.
- Write 10 to address 100, then read 100: both granted, err pulses each time, rd_data=00, no cell 0..99 changes.
- Board filled, clr_start pulsed, second clr_start 20 cycles later:
  - Single clr_done 100 cycles after the first.
  - A wr_req held during the clear is granted the cycle after busy falls.
- rst asserted at clr_ptr=50 with rd_req pending:
  - No rd_valid.
  - Clear restarts at cell 0 and busy lasts 100 cycles from rst release.
